// File: rtl/group_add_tree_pkg.sv
// Shared helpers for the group_add_tree adder: tree depth and per-level entry counts.
package group_add_tree_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Entries alive at tree level lvl: ceil(n / 2^lvl)
  function automatic int unsigned level_nb(input int unsigned n, input int unsigned lvl);
    return (n + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

endpackage

// File: rtl/group_add_tree_if.sv
// Upstream operand bus and downstream sum bus of group_add_tree.
interface group_add_tree_if #(
  parameter int unsigned GROUP_NB  = 4,
  parameter int unsigned NUM_WIDTH = 16
);
  logic [GROUP_NB*NUM_WIDTH-1:0] up_data;
  logic                          up_val;
  logic                          up_rdy;
  logic [NUM_WIDTH-1:0]          dn_data;
  logic                          dn_val;
  logic                          dn_rdy;
  logic                          dn_ovf;

  modport master (
    output up_data, up_val, dn_rdy,
    input  up_rdy, dn_data, dn_val, dn_ovf
  );

  modport slave (
    input  up_data, up_val, dn_rdy,
    output up_rdy, dn_data, dn_val, dn_ovf
  );
endinterface

// File: rtl/group_add_level.sv
// One registered adder-tree level: pairwise sign-extended sums, odd trailing entry
// passes through; local valid bit with ready = ~valid | downstream ready.
module group_add_level #(
  parameter int unsigned IN_NB    = 2,
  parameter int unsigned IN_WIDTH = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [IN_NB*IN_WIDTH-1:0]                  in_data,
  input  logic                                       in_val,
  output logic                                       in_rdy_c,
  output logic [((IN_NB+1)/2)*(IN_WIDTH+1)-1:0]      out_data,
  output logic                                       out_val,
  input  logic                                       out_rdy
);
  localparam int unsigned OUT_NB = (IN_NB + 1) / 2;
  localparam int unsigned OW     = IN_WIDTH + 1;

  logic [OUT_NB*OW-1:0] sum_c;
  (* use_dsp48 = "no" *) logic [OUT_NB*OW-1:0] data_q;
  logic                 val_q;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(IN_NB / 2); i++) begin
      sum_c[i*OW +: OW] = OW'($signed(in_data[2*i*IN_WIDTH +: IN_WIDTH]))
                        + OW'($signed(in_data[(2*i+1)*IN_WIDTH +: IN_WIDTH]));
    end
    if ((IN_NB % 2) == 1) begin
      sum_c[(OUT_NB-1)*OW +: OW] = OW'($signed(in_data[(IN_NB-1)*IN_WIDTH +: IN_WIDTH]));
    end
  end

  assign in_rdy_c = ~val_q | out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= 1'b0;
      data_q <= '0;
    end else if (in_rdy_c) begin
      val_q <= in_val;
      if (in_val) data_q <= sum_c;
    end
  end

  assign out_data = data_q;
  assign out_val  = val_q;
endmodule

// File: rtl/group_add_tree.sv
// Pipelined signed adder tree over GROUP_NB operands with valid/ready flow control
// and wrap or saturate output. Stages: input reg, LEVELS tree levels, output reg.
module group_add_tree
  import group_add_tree_pkg::*;
#(
  parameter int unsigned GROUP_NB  = 4,
  parameter int unsigned NUM_WIDTH = 16,
  parameter int unsigned SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  group_add_tree_if.slave  bus
);
  localparam int unsigned LEVELS = clog2(GROUP_NB);
  localparam int unsigned FULL_W = NUM_WIDTH + LEVELS;

  (* use_dsp48 = "no" *) logic [GROUP_NB*NUM_WIDTH-1:0] s0_data;
  logic                 s0_val;
  logic                 s0_rdy_c;
  logic                 s0_next_rdy_c;
  logic [FULL_W-1:0]    full_c;
  logic                 tree_val_c;
  logic                 out_rdy_c;
  logic [LEVELS:0]      top_c;
  logic                 ovf_c;
  logic [NUM_WIDTH-1:0] res_c;
  logic [NUM_WIDTH-1:0] dn_data_q;
  logic                 dn_val_q;
  logic                 dn_ovf_q;

  // Ready chain runs combinationally back from dn_rdy; up_val never feeds it
  assign out_rdy_c  = ~dn_val_q | bus.dn_rdy;
  assign s0_rdy_c   = ~s0_val | s0_next_rdy_c;
  assign bus.up_rdy = s0_rdy_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_val  <= 1'b0;
      s0_data <= '0;
    end else if (s0_rdy_c) begin
      s0_val <= bus.up_val;
      if (bus.up_val) s0_data <= bus.up_data;
    end
  end

  if (LEVELS == 0) begin : g_flat
    assign full_c        = s0_data;
    assign tree_val_c    = s0_val;
    assign s0_next_rdy_c = out_rdy_c;
  end else begin : g_tree
    for (genvar j = 0; j < int'(LEVELS); j++) begin : g_lvl
      localparam int unsigned IN_NB  = level_nb(GROUP_NB, j);
      localparam int unsigned OUT_NB = level_nb(GROUP_NB, j + 1);
      localparam int unsigned IN_W   = NUM_WIDTH + j;

      logic [IN_NB*IN_W-1:0]      in_data;
      logic                       in_val;
      logic                       in_rdy_c;
      logic [OUT_NB*(IN_W+1)-1:0] out_data;
      logic                       out_val;
      logic                       out_rdy;

      if (j == 0) begin : g_src
        assign in_data = s0_data;
        assign in_val  = s0_val;
      end else begin : g_src
        assign in_data = g_lvl[j-1].out_data;
        assign in_val  = g_lvl[j-1].out_val;
      end

      if (j == int'(LEVELS) - 1) begin : g_snk
        assign out_rdy = out_rdy_c;
      end else begin : g_snk
        assign out_rdy = g_lvl[j+1].in_rdy_c;
      end

      group_add_level #(
        .IN_NB    (IN_NB),
        .IN_WIDTH (IN_W)
      ) u_level (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_val   (in_val),
        .in_rdy_c (in_rdy_c),
        .out_data (out_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy)
      );
    end
    assign full_c        = g_lvl[LEVELS-1].out_data;
    assign tree_val_c    = g_lvl[LEVELS-1].out_val;
    assign s0_next_rdy_c = g_lvl[0].in_rdy_c;
  end

  // Exact sum fits NUM_WIDTH only if the top LEVELS+1 bits are all sign copies
  assign top_c = full_c[FULL_W-1 -: LEVELS+1];
  assign ovf_c = ~((&top_c) | ~(|top_c));

  always_comb begin
    res_c = full_c[NUM_WIDTH-1:0];
    if ((SATURATE != 0) && ovf_c) begin
      res_c = full_c[FULL_W-1] ? {1'b1, {(NUM_WIDTH-1){1'b0}}}
                               : {1'b0, {(NUM_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_val_q  <= 1'b0;
      dn_data_q <= '0;
      dn_ovf_q  <= 1'b0;
    end else if (out_rdy_c) begin
      dn_val_q <= tree_val_c;
      if (tree_val_c) begin
        dn_data_q <= res_c;
        dn_ovf_q  <= ovf_c;
      end
    end
  end

  assign bus.dn_data = dn_data_q;
  assign bus.dn_val  = dn_val_q;
  assign bus.dn_ovf  = dn_ovf_q;
endmodule

// File: tb/tb_group_add_tree.sv
// Scoreboard bench for group_add_tree across five parameter sets; stimulus pushes
// expected beats, a monitor pops and compares on every downstream handshake.
module tb_group_add_tree;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        ovf;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        q[5][$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  bit          prev_stall[5];
  logic [15:0] prev_d[5];
  logic        prev_ovf[5];

  group_add_tree_if #(.GROUP_NB(4), .NUM_WIDTH(16)) if_a ();
  group_add_tree_if #(.GROUP_NB(3), .NUM_WIDTH(16)) if_b ();
  group_add_tree_if #(.GROUP_NB(3), .NUM_WIDTH(16)) if_c ();
  group_add_tree_if #(.GROUP_NB(5), .NUM_WIDTH(8))  if_d ();
  group_add_tree_if #(.GROUP_NB(1), .NUM_WIDTH(16)) if_e ();

  group_add_tree #(.GROUP_NB(4), .NUM_WIDTH(16), .SATURATE(0)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  group_add_tree #(.GROUP_NB(3), .NUM_WIDTH(16), .SATURATE(0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  group_add_tree #(.GROUP_NB(3), .NUM_WIDTH(16), .SATURATE(1)) u_c (.clk(clk), .rst(rst), .bus(if_c));
  group_add_tree #(.GROUP_NB(5), .NUM_WIDTH(8),  .SATURATE(1)) u_d (.clk(clk), .rst(rst), .bus(if_d));
  group_add_tree #(.GROUP_NB(1), .NUM_WIDTH(16), .SATURATE(0)) u_e (.clk(clk), .rst(rst), .bus(if_e));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic dn_of(input int id, output logic v, output logic r,
                       output logic [15:0] d, output logic o);
    case (id)
      0: begin v = if_a.dn_val; r = if_a.dn_rdy; d = if_a.dn_data;      o = if_a.dn_ovf; end
      1: begin v = if_b.dn_val; r = if_b.dn_rdy; d = if_b.dn_data;      o = if_b.dn_ovf; end
      2: begin v = if_c.dn_val; r = if_c.dn_rdy; d = if_c.dn_data;      o = if_c.dn_ovf; end
      3: begin v = if_d.dn_val; r = if_d.dn_rdy; d = 16'(if_d.dn_data); o = if_d.dn_ovf; end
      default: begin v = if_e.dn_val; r = if_e.dn_rdy; d = if_e.dn_data; o = if_e.dn_ovf; end
    endcase
  endtask

  task automatic drive_up(input int id, input logic [79:0] d, input logic v);
    case (id)
      0: begin if_a.up_data = 64'(d); if_a.up_val = v; end
      1: begin if_b.up_data = 48'(d); if_b.up_val = v; end
      2: begin if_c.up_data = 48'(d); if_c.up_val = v; end
      3: begin if_d.up_data = 40'(d); if_d.up_val = v; end
      default: begin if_e.up_data = 16'(d); if_e.up_val = v; end
    endcase
  endtask

  function automatic logic up_rdy_of(input int id);
    case (id)
      0: return if_a.up_rdy;
      1: return if_b.up_rdy;
      2: return if_c.up_rdy;
      3: return if_d.up_rdy;
      default: return if_e.up_rdy;
    endcase
  endfunction

  // Present one beat, wait for up_rdy, record the expected result; lat<0 skips latency check
  task automatic send(input int id, input logic [79:0] d, input logic [15:0] ed,
                      input logic eo, input int lat, output int acc);
    int   n;
    exp_t e;
    @(negedge clk);
    drive_up(id, d, 1'b1);
    #2;
    n = 0;
    while (!up_rdy_of(id) && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    acc = cyc;
    if (!up_rdy_of(id)) begin
      checks++;
      fails++;
      $display("FAIL send%0d: up_rdy stuck low for %0d cycles", id, n);
      drive_up(id, '1, 1'b0);
    end else begin
      @(posedge clk);
      e = '{d: ed, ovf: eo, acc: acc, lat: lat};
      q[id].push_back(e);
      #1 drive_up(id, '1, 1'b0);
    end
  endtask

  task automatic wait_drain(input int id);
    int n;
    n = 0;
    while (q[id].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q[id].size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain%0d: %0d beats still pending, expected 0", id, q[id].size());
    end
  endtask

  task automatic mon_step(input int i);
    logic        v, r, o;
    logic [15:0] d;
    exp_t        e;
    dn_of(i, v, r, d, o);
    if (prev_stall[i]) begin
      chk($sformatf("hold_val%0d", i), 32'(v), 32'd1);
      chk($sformatf("hold_data%0d", i), 32'(d), 32'(prev_d[i]));
      chk($sformatf("hold_ovf%0d", i), 32'(o), 32'(prev_ovf[i]));
    end
    prev_stall[i] = v & ~r;
    prev_d[i]     = d;
    prev_ovf[i]   = o;
    if (v && r) begin
      if (q[i].size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected%0d: got beat data %0h expected no beat", i, d);
      end else begin
        e = q[i].pop_front();
        chk($sformatf("data%0d", i), 32'(d), 32'(e.d));
        chk($sformatf("ovf%0d", i), 32'(o), 32'(e.ovf));
        if (e.lat >= 0) chk($sformatf("latency%0d", i), 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst) begin
      for (int i = 0; i < 5; i++) prev_stall[i] = 1'b0;
    end else begin
      // A 4-operand pipe has 4 slots; up_rdy may drop only with all of them full
      if (!if_a.up_rdy) chk("up_rdy_low_when_full", 32'(q[0].size()), 32'd4);
      for (int i = 0; i < 5; i++) mon_step(i);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          a_first;
    int          a_last;
    bit          done4;
    logic        v, r, o;
    logic [15:0] d;

    for (int i = 0; i < 5; i++) drive_up(i, '0, 1'b0);
    if_a.dn_rdy = 1'b1; if_b.dn_rdy = 1'b1; if_c.dn_rdy = 1'b1;
    if_d.dn_rdy = 1'b1; if_e.dn_rdy = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    for (int i = 0; i < 5; i++) begin
      dn_of(i, v, r, d, o);
      chk($sformatf("rst_val%0d", i), 32'(v), 32'd0);
      chk($sformatf("rst_data%0d", i), 32'(d), 32'd0);
      chk($sformatf("rst_ovf%0d", i), 32'(o), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // N=4 wrap: basic sum with latency, then overflow boundaries
    send(0, {16'd4, 16'd3, 16'd2, 16'd1}, 16'd10, 1'b0, 4, acc);
    send(0, {4{16'h7FFF}}, 16'hFFFC, 1'b1, 4, acc);
    send(0, {4{16'hFFFF}}, 16'hFFFC, 1'b0, 4, acc);
    send(0, {16'h0000, 16'h0000, 16'h8000, 16'h8000}, 16'h0000, 1'b1, 4, acc);
    wait_drain(0);

    // N=3 wrap vs saturate
    send(1, {16'h0000, 16'h0001, 16'h7FFF}, 16'h8000, 1'b1, 4, acc);
    send(2, {16'h0000, 16'h0001, 16'h7FFF}, 16'h7FFF, 1'b1, 4, acc);
    send(2, {16'hFFFF, 16'h8000, 16'h8000}, 16'h8000, 1'b1, 4, acc);
    send(2, {16'hFFFE, 16'h0005, 16'h0001}, 16'h0004, 1'b0, 4, acc);
    wait_drain(1);
    wait_drain(2);

    // N=5, W=8 saturate: odd pass-through and exact range edges
    send(3, {8'h00, 8'h00, 8'hFF, 8'h80, 8'h80}, 16'h0080, 1'b1, 5, acc);
    send(3, {8'h02, 8'hFF, 8'h07, 8'h05, 8'hFD}, 16'h000A, 1'b0, 5, acc);
    send(3, {8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F}, 16'h007F, 1'b1, 5, acc);
    send(3, {8'h00, 8'h00, 8'h00, 8'h7F, 8'h00}, 16'h007F, 1'b0, 5, acc);
    send(3, {8'hFF, 8'h00, 8'h00, 8'h00, 8'h81}, 16'h0080, 1'b0, 5, acc);
    wait_drain(3);

    // N=1: latency 2 and one accept per cycle
    send(4, 80'(16'hFFF9), 16'hFFF9, 1'b0, 2, a_first);
    send(4, 80'(16'd100),  16'd100,  1'b0, 2, acc);
    send(4, 80'(16'hFF38), 16'hFF38, 1'b0, 2, acc);
    send(4, 80'(16'h7FFF), 16'h7FFF, 1'b0, 2, acc);
    send(4, 80'(16'h8000), 16'h8000, 1'b0, 2, a_last);
    chk("e_throughput", 32'(a_last - a_first), 32'd4);
    wait_drain(4);

    // N=4 stream under random back-pressure
    done4 = 1'b0;
    fork
      begin
        int dummy;
        for (int k = 0; k < 20; k++)
          send(0, {4{16'(k)}}, 16'(4 * k), 1'b0, -1, dummy);
        done4 = 1'b1;
      end
      begin
        while (!done4) begin
          @(negedge clk);
          if_a.dn_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    if_a.dn_rdy = 1'b1;
    wait_drain(0);

    // Reset with beats in flight and one held at the output
    if_a.dn_rdy = 1'b0;
    send(0, {4{16'd1}}, 16'd4, 1'b0, -1, acc);
    send(0, {4{16'd2}}, 16'd8, 1'b0, -1, acc);
    send(0, {4{16'd3}}, 16'd12, 1'b0, -1, acc);
    repeat (3) @(negedge clk);
    #3;
    chk("pre_rst_dn_val", 32'(if_a.dn_val), 32'd1);
    rst = 1'b1;
    q[0].delete();
    #1;
    chk("mid_rst_dn_val", 32'(if_a.dn_val), 32'd0);
    chk("mid_rst_dn_data", 32'(if_a.dn_data), 32'd0);
    chk("mid_rst_dn_ovf", 32'(if_a.dn_ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    if_a.dn_rdy = 1'b1;
    repeat (8) @(negedge clk);
    send(0, {16'd4, 16'd3, 16'd2, 16'd1}, 16'd10, 1'b0, 4, acc);
    wait_drain(0);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++)
      chk($sformatf("final_empty%0d", i), 32'(q[i].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
